// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multicycle controller: FSM state encoding,
// opcode match values with their don't-care masks, ALU operation codes and
// the instruction-class bundle produced by the opcode decoder.
package legv8_ctrl_pkg;

    localparam int OPCODE_W = 11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcode values; a 0 bit in the mask marks a field that belongs to the
    // immediate (CBZ register / B offset) rather than the opcode.
    localparam logic [OPCODE_W-1:0] OP_ADD    = 11'b10001011000;
    localparam logic [OPCODE_W-1:0] MASK_ADD  = 11'b11111111111;
    localparam logic [OPCODE_W-1:0] OP_SUB    = 11'b11001011000;
    localparam logic [OPCODE_W-1:0] MASK_SUB  = 11'b11111111111;
    localparam logic [OPCODE_W-1:0] OP_AND    = 11'b10001010000;
    localparam logic [OPCODE_W-1:0] MASK_AND  = 11'b11111111111;
    localparam logic [OPCODE_W-1:0] OP_ORR    = 11'b10101010000;
    localparam logic [OPCODE_W-1:0] MASK_ORR  = 11'b11111111111;
    localparam logic [OPCODE_W-1:0] OP_LDUR   = 11'b11111000010;
    localparam logic [OPCODE_W-1:0] MASK_LDUR = 11'b11111111111;
    localparam logic [OPCODE_W-1:0] OP_STUR   = 11'b11111000000;
    localparam logic [OPCODE_W-1:0] MASK_STUR = 11'b11111111111;
    localparam logic [OPCODE_W-1:0] OP_CBZ    = 11'b10110100000;
    localparam logic [OPCODE_W-1:0] MASK_CBZ  = 11'b11111111000;
    localparam logic [OPCODE_W-1:0] OP_B      = 11'b00010100000;
    localparam logic [OPCODE_W-1:0] MASK_B    = 11'b11111100000;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef struct packed {
        logic valid;
        logic rtype;
        logic load;
        logic store;
        logic cbz;
        logic br;
    } op_class_t;

    // Masked compare: bits cleared in the mask never affect the result.
    function automatic logic op_match(input logic [OPCODE_W-1:0] op,
                                      input logic [OPCODE_W-1:0] value,
                                      input logic [OPCODE_W-1:0] mask);
        return ((op & mask) == (value & mask));
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode decoder: ALU operation code and instruction class.
import legv8_ctrl_pkg::*;

module alu_decoder #(
    parameter int OPW = 11
) (
    input  logic [OPW-1:0] opcode,
    output logic [3:0]     alu_control,
    output op_class_t      op_class
);

    // Priority chain over the recognised opcodes; anything else is invalid.
    always_comb begin
        alu_control = 4'b0000;
        op_class    = '0;
        if (op_match(opcode, OP_ADD, MASK_ADD)) begin
            alu_control    = ALU_ADD;
            op_class.valid = 1'b1;
            op_class.rtype = 1'b1;
        end else if (op_match(opcode, OP_SUB, MASK_SUB)) begin
            alu_control    = ALU_SUB;
            op_class.valid = 1'b1;
            op_class.rtype = 1'b1;
        end else if (op_match(opcode, OP_AND, MASK_AND)) begin
            alu_control    = ALU_AND;
            op_class.valid = 1'b1;
            op_class.rtype = 1'b1;
        end else if (op_match(opcode, OP_ORR, MASK_ORR)) begin
            alu_control    = ALU_ORR;
            op_class.valid = 1'b1;
            op_class.rtype = 1'b1;
        end else if (op_match(opcode, OP_LDUR, MASK_LDUR)) begin
            alu_control    = ALU_ADD;
            op_class.valid = 1'b1;
            op_class.load  = 1'b1;
        end else if (op_match(opcode, OP_STUR, MASK_STUR)) begin
            alu_control    = ALU_ADD;
            op_class.valid = 1'b1;
            op_class.store = 1'b1;
        end else if (op_match(opcode, OP_CBZ, MASK_CBZ)) begin
            alu_control    = ALU_PASSB;
            op_class.valid = 1'b1;
            op_class.cbz   = 1'b1;
        end else if (op_match(opcode, OP_B, MASK_B)) begin
            alu_control    = ALU_AND;
            op_class.valid = 1'b1;
            op_class.br    = 1'b1;
        end else begin
            alu_control = 4'b0000;
            op_class    = '0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multicycle controller. Strobes are decoded combinationally from the
// state register and live inputs so FETCH/MEM can complete in the same cycle
// mem_ready arrives; every strobe is gated by reset so asserting it silences
// the datapath without waiting for a clock edge.
import legv8_ctrl_pkg::*;

module multicycle_control #(
    parameter int OPW = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero_E,
    input  logic           mem_ready,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic           PCSrc,
    output logic           memRead,
    output logic           memWrite,
    output logic           regWrite,
    output logic           memtoReg,
    output logic           Reg2Loc,
    output logic           AluSrc,
    output logic [3:0]     AluControl,
    output logic           illegal,
    output logic [31:0]    retired
);

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] retired_r;
    logic        retire_s;

    logic [3:0]  dec_alu_s;
    op_class_t   cls_s;

    logic        ir_write_s;
    logic        pc_write_s;
    logic        pc_src_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic        memto_reg_s;
    logic        reg2loc_s;
    logic        alu_src_s;
    logic [3:0]  alu_s;

    alu_decoder #(.OPW(OPW)) u_alu_decoder (
        .opcode      (opcode),
        .alu_control (dec_alu_s),
        .op_class    (cls_s)
    );

    // Next-state and per-state strobe decode; opcode is ignored in FETCH.
    always_comb begin
        next_state_s = state_r;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        memto_reg_s  = 1'b0;
        reg2loc_s    = 1'b0;
        alu_src_s    = 1'b0;
        alu_s        = 4'b0000;
        case (state_r)
            ST_FETCH: begin
                mem_read_s = 1'b1;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    pc_src_s     = 1'b0;
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                reg2loc_s = cls_s.store | cls_s.cbz;
                if (cls_s.valid) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            ST_EXEC: begin
                alu_s     = dec_alu_s;
                reg2loc_s = cls_s.store | cls_s.cbz;
                alu_src_s = cls_s.load | cls_s.store;
                if (cls_s.rtype) begin
                    next_state_s = ST_WB;
                end else if (cls_s.load | cls_s.store) begin
                    next_state_s = ST_MEM;
                end else if (cls_s.cbz) begin
                    pc_write_s   = zero_E;
                    pc_src_s     = zero_E;
                    next_state_s = ST_FETCH;
                end else if (cls_s.br) begin
                    pc_write_s   = 1'b1;
                    pc_src_s     = 1'b1;
                    next_state_s = ST_FETCH;
                end else begin
                    // IR changed under us: stop rather than guess.
                    next_state_s = ST_HALT;
                end
            end
            ST_MEM: begin
                alu_s     = dec_alu_s;
                alu_src_s = cls_s.load | cls_s.store;
                if (cls_s.load) begin
                    mem_read_s   = 1'b1;
                    next_state_s = mem_ready ? ST_WB : ST_MEM;
                end else if (cls_s.store) begin
                    mem_write_s  = 1'b1;
                    next_state_s = mem_ready ? ST_FETCH : ST_MEM;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            ST_WB: begin
                alu_s        = dec_alu_s;
                reg_write_s  = 1'b1;
                memto_reg_s  = cls_s.load;
                next_state_s = ST_FETCH;
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                // Unused encodings are treated as a fault.
                next_state_s = ST_HALT;
            end
        endcase
    end

    // An instruction retires when it leaves EXEC, MEM or WB for FETCH.
    always_comb begin
        if ((next_state_s == ST_FETCH) &&
            ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB))) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_r <= 32'd0;
        end else if (retire_s) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign IRWrite    = reset & ir_write_s;
    assign PCWrite    = reset & pc_write_s;
    assign PCSrc      = reset & pc_src_s;
    assign memRead    = reset & mem_read_s;
    assign memWrite   = reset & mem_write_s;
    assign regWrite   = reset & reg_write_s;
    assign memtoReg   = reset & memto_reg_s;
    assign Reg2Loc    = reset & reg2loc_s;
    assign AluSrc     = reset & alu_src_s;
    assign AluControl = {4{reset}} & alu_s;
    // HALT is only reachable through an unrecognised opcode, so it doubles
    // as the sticky illegal flag.
    assign illegal    = reset & (state_r == ST_HALT);
    assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle strobe vectors written by
// hand for each instruction class, plus reset and illegal-opcode scenarios.
`timescale 1ns/1ps

module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [10:0] opcode;
    logic        zero_E;
    logic        mem_ready;
    logic        IRWrite, PCWrite, PCSrc, memRead, memWrite;
    logic        regWrite, memtoReg, Reg2Loc, AluSrc;
    logic [3:0]  AluControl;
    logic        illegal;
    logic [31:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDI = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] BR   = 11'b00010110011;
    localparam logic [10:0] BAD  = 11'b11111111111;

    multicycle_control #(.OPW(11)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero_E(zero_E),
        .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .memRead(memRead), .memWrite(memWrite),
        .regWrite(regWrite), .memtoReg(memtoReg), .Reg2Loc(Reg2Loc),
        .AluSrc(AluSrc), .AluControl(AluControl), .illegal(illegal),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite,PCWrite,PCSrc,memRead,memWrite,regWrite,memtoReg,Reg2Loc,AluSrc,AluControl,illegal}
    logic [13:0] obs;
    assign obs = {IRWrite, PCWrite, PCSrc, memRead, memWrite, regWrite,
                  memtoReg, Reg2Loc, AluSrc, AluControl, illegal};

    function automatic logic [13:0] ev(input logic ir, input logic pcw, input logic pcs,
                                       input logic mr, input logic mw, input logic rw,
                                       input logic m2r, input logic r2l, input logic as,
                                       input logic [3:0] alu, input logic ill);
        return {ir, pcw, pcs, mr, mw, rw, m2r, r2l, as, alu, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check strobes mid-cycle, advance to posedge+1.
    task automatic cyc(input string tag, input logic [10:0] op, input logic mr,
                       input logic z, input logic [13:0] exp);
        opcode    = op;
        mem_ready = mr;
        zero_E    = z;
        @(negedge clk);
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    logic [13:0] v_fetch;
    logic [13:0] v_zero;

    initial begin
        v_fetch = ev(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        v_zero  = 14'd0;
        reset = 1'b0; opcode = BAD; zero_E = 1'b0; mem_ready = 1'b1;
        #1;
        check("rst_strobes", 32'(obs), 32'd0);
        check("rst_retired", retired, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // ADD; garbage opcode in FETCH and mem_ready low in DECODE must not matter
        cyc("add_fetch", BAD, 1'b1, 1'b0, v_fetch);
        cyc("add_dec",   ADD, 1'b0, 1'b0, v_zero);
        cyc("add_exec",  ADD, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,4'b0010,0));
        cyc("add_wb",    ADD, 1'b1, 1'b0, ev(0,0,0,0,0,1,0,0,0,4'b0010,0));
        check("add_ret", retired, 32'd1);

        // LDUR with three wait cycles in MEM: 8 cycles total
        cyc("ld_fetch", BAD,  1'b1, 1'b0, v_fetch);
        cyc("ld_dec",   LDUR, 1'b1, 1'b0, v_zero);
        cyc("ld_exec",  LDUR, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,1,4'b0010,0));
        for (int i = 0; i < 3; i++)
            cyc("ld_memw", LDUR, 1'b0, 1'b0, ev(0,0,0,1,0,0,0,0,1,4'b0010,0));
        cyc("ld_mem",   LDUR, 1'b1, 1'b0, ev(0,0,0,1,0,0,0,0,1,4'b0010,0));
        check("ld_ret_mid", retired, 32'd1);
        cyc("ld_wb",    LDUR, 1'b1, 1'b0, ev(0,0,0,0,0,1,1,0,0,4'b0010,0));
        check("ld_ret", retired, 32'd2);

        // STUR with one FETCH wait
        cyc("st_fwait", BAD,  1'b0, 1'b0, ev(0,0,0,1,0,0,0,0,0,4'b0000,0));
        cyc("st_fetch", BAD,  1'b1, 1'b0, v_fetch);
        cyc("st_dec",   STUR, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,1,0,4'b0000,0));
        cyc("st_exec",  STUR, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,1,1,4'b0010,0));
        cyc("st_mem",   STUR, 1'b1, 1'b0, ev(0,0,0,0,1,0,0,0,1,4'b0010,0));
        check("st_ret", retired, 32'd3);

        // CBZ taken / not taken
        cyc("cbz1_fetch", BAD, 1'b1, 1'b0, v_fetch);
        cyc("cbz1_dec",   CBZ, 1'b1, 1'b1, ev(0,0,0,0,0,0,0,1,0,4'b0000,0));
        cyc("cbz1_exec",  CBZ, 1'b1, 1'b1, ev(0,1,1,0,0,0,0,1,0,4'b0111,0));
        check("cbz1_ret", retired, 32'd4);
        cyc("cbz0_fetch", BAD, 1'b1, 1'b1, v_fetch);
        cyc("cbz0_dec",   CBZ, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,1,0,4'b0000,0));
        cyc("cbz0_exec",  CBZ, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,1,0,4'b0111,0));
        check("cbz0_ret", retired, 32'd5);

        // Unconditional branch
        cyc("b_fetch", BAD, 1'b1, 1'b0, v_fetch);
        cyc("b_dec",   BR,  1'b1, 1'b0, v_zero);
        cyc("b_exec",  BR,  1'b1, 1'b0, ev(0,1,1,0,0,0,0,0,0,4'b0000,0));
        check("b_ret", retired, 32'd6);

        // SUB, AND, ORR ALU codes
        cyc("sub_fetch", BAD, 1'b1, 1'b0, v_fetch);
        cyc("sub_dec",   SUB, 1'b1, 1'b0, v_zero);
        cyc("sub_exec",  SUB, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0,4'b0110,0));
        cyc("sub_wb",    SUB, 1'b1, 1'b0, ev(0,0,0,0,0,1,0,0,0,4'b0110,0));
        cyc("and_fetch", BAD,  1'b1, 1'b0, v_fetch);
        cyc("and_dec",   ANDI, 1'b1, 1'b0, v_zero);
        cyc("and_exec",  ANDI, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0,4'b0000,0));
        cyc("and_wb",    ANDI, 1'b1, 1'b0, ev(0,0,0,0,0,1,0,0,0,4'b0000,0));
        cyc("orr_fetch", BAD, 1'b1, 1'b0, v_fetch);
        cyc("orr_dec",   ORR, 1'b1, 1'b0, v_zero);
        cyc("orr_exec",  ORR, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0,4'b0001,0));
        cyc("orr_wb",    ORR, 1'b1, 1'b0, ev(0,0,0,0,0,1,0,0,0,4'b0001,0));
        check("alu_ret", retired, 32'd9);

        // STUR interrupted by an asynchronous reset in MEM
        cyc("rs_fetch", BAD,  1'b1, 1'b0, v_fetch);
        cyc("rs_dec",   STUR, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,1,0,4'b0000,0));
        cyc("rs_exec",  STUR, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,1,1,4'b0010,0));
        mem_ready = 1'b0;
        @(negedge clk);
        check("rs_mem_wr", 32'(obs), 32'(ev(0,0,0,0,1,0,0,0,1,4'b0010,0)));
        #2;
        reset = 1'b0;
        #1;
        check("rs_async_drop", 32'(obs), 32'd0);
        check("rs_async_ret", retired, 32'd0);
        @(posedge clk); #1;
        check("rs_held", 32'(obs), 32'd0);
        reset = 1'b1;
        cyc("rs_first_fetch", STUR, 1'b0, 1'b0, ev(0,0,0,1,0,0,0,0,0,4'b0000,0));
        check("rs_illegal", 32'(illegal), 32'd0);

        // Illegal opcode: HALT with only the illegal flag, retired unchanged
        cyc("ill_fetch", BAD, 1'b1, 1'b0, v_fetch);
        cyc("ill_dec",   BAD, 1'b1, 1'b0, v_zero);
        for (int i = 0; i < 10; i++)
            cyc("ill_halt", ADD, 1'b1, 1'b1, ev(0,0,0,0,0,0,0,0,0,4'b0000,1));
        check("ill_ret", retired, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
